// File: rtl/alu_sequencer.sv
// alu_sequencer: FIFO-buffered instruction issue sequencer stepping ISSUE/DECODE/EXEC/WRITE
module alu_sequencer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             InValid,
  input  logic [15:0]      InInstr,
  output logic             InReady,
  input  logic             Halt,
  output logic [15:0]      DecInstr,
  input  logic             DecValid,
  output logic             Wen,
  output logic             Rdy,
  output logic             Busy,
  output logic             Err,
  input  logic             ErrClr,
  output logic [CNT_W-1:0] RetCount
);
  typedef enum logic [2:0] {IDLE, ISSUE, DECODE, EXEC, WRITE} state_t;
  state_t state;
  logic [15:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0] count;
  logic valid_q, pop, push;
  assign InReady = count != (PTR_W+1)'(DEPTH);
  assign pop = (state == IDLE || state == WRITE) && count != '0 && !Halt;
  assign push = InValid && (InReady || pop);
  assign Busy = state != IDLE || count != '0;
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      DecInstr <= '0;
      valid_q <= 1'b0;
      Wen <= 1'b0;
      Rdy <= 1'b0;
      Err <= 1'b0;
      RetCount <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= InInstr;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        DecInstr <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
      state <= pop ? ISSUE : state == ISSUE ? DECODE : state == DECODE ? EXEC : state == EXEC ? WRITE : IDLE;
      if (state == DECODE) valid_q <= DecValid;
      Wen <= state == EXEC && valid_q;
      Rdy <= state == EXEC;
      if (state == WRITE && valid_q) RetCount <= RetCount + 1'b1;
      Err <= (state == WRITE && !valid_q) || (Err && !ErrClr);
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: randomized and directed checks of alu_sequencer against a transaction-level model
module tb_alu_sequencer;
  logic CLK = 1'b0, RST = 1'b1, InValid = 1'b0, Halt = 1'b0, ErrClr = 1'b0;
  logic [15:0] InInstr = '0;
  logic InReady, Wen, Rdy, Busy, Err, DecValid;
  logic [15:0] DecInstr;
  logic [7:0] RetCount;
  logic in_ready2, wen2, rdy2, busy2, err2;
  logic [15:0] dec_instr2;
  logic [1:0] ret_count2;
  int n_chk = 0, n_pass = 0;
  logic [15:0] q[$];
  logic [15:0] cur = '0;
  int stage = 0, cnt = 0;
  bit err = 0;
  always #5 CLK = ~CLK;
  function automatic bit ok(logic [15:0] x);
    return x[15:12] != 4'hF;
  endfunction
  assign DecValid = ok(DecInstr);
  alu_sequencer dut (
    .CLK(CLK), .RST(RST), .InValid(InValid), .InInstr(InInstr), .InReady(InReady), .Halt(Halt),
    .DecInstr(DecInstr), .DecValid(DecValid), .Wen(Wen), .Rdy(Rdy), .Busy(Busy), .Err(Err),
    .ErrClr(ErrClr), .RetCount(RetCount)
  );
  alu_sequencer #(.CNT_W(2)) dut2 (
    .CLK(CLK), .RST(RST), .InValid(InValid), .InInstr(InInstr), .InReady(in_ready2), .Halt(Halt),
    .DecInstr(dec_instr2), .DecValid(ok(dec_instr2)), .Wen(wen2), .Rdy(rdy2), .Busy(busy2), .Err(err2),
    .ErrClr(ErrClr), .RetCount(ret_count2)
  );
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask
  task automatic step();
    bit wr, pp, ps;
    if (RST) begin
      q.delete();
      stage = 0;
      cnt = 0;
      err = 0;
      cur = '0;
    end else begin
      wr = stage == 4;
      pp = (stage == 0 || wr) && q.size() > 0 && !Halt;
      ps = InValid && (q.size() < 4 || pp);
      if (wr && ok(cur)) cnt++;
      if (wr && !ok(cur)) err = 1;
      else if (ErrClr) err = 0;
      if (pp) begin
        cur = q.pop_front();
        stage = 1;
      end else stage = (stage == 0 || stage == 4) ? 0 : stage + 1;
      if (ps) q.push_back(InInstr);
    end
    @(posedge CLK);
    #1;
    chk("InReady", InReady, q.size() != 4);
    chk("Rdy", Rdy, stage == 4);
    chk("Wen", Wen, stage == 4 && ok(cur));
    chk("Busy", Busy, stage != 0 || q.size() != 0);
    chk("Err", Err, err);
    chk("DecInstr", DecInstr, cur);
    chk("RetCount", RetCount, cnt % 256);
    chk("RetCount2", ret_count2, cnt % 4);
  endtask
  task automatic push_word(logic [15:0] w);
    InValid = 1'b1;
    InInstr = w;
    step();
    InValid = 1'b0;
  endtask
  initial begin
    RST = 1'b1;
    repeat (2) step();
    RST = 1'b0;
    push_word(16'h1234);
    repeat (8) step();
    Halt = 1'b1;
    for (int i = 0; i < 5; i++) push_word(16'hA000 + 16'(i));
    Halt = 1'b0;
    repeat (20) step();
    Halt = 1'b1;
    for (int i = 0; i < 4; i++) push_word(16'hB000 + 16'(i));
    Halt = 1'b0;
    for (int i = 0; i < 12; i++) push_word(16'hC000 + 16'(i));
    repeat (30) step();
    push_word(16'h1111);
    push_word(16'hF00D);
    push_word(16'h3333);
    repeat (14) step();
    ErrClr = 1'b1;
    step();
    ErrClr = 1'b0;
    step();
    push_word(16'h5555);
    for (int i = 0; i < 20 && stage != 3; i++) step();
    RST = 1'b1;
    repeat (2) step();
    RST = 1'b0;
    repeat (6) step();
    for (int i = 0; i < 6; i++) push_word(16'h0100 + 16'(i));
    repeat (24) step();
    repeat (400) begin
      RST = $urandom_range(0, 99) == 0;
      InValid = $urandom_range(0, 1) == 1;
      InInstr = 16'($urandom);
      Halt = $urandom_range(0, 3) == 0;
      ErrClr = $urandom_range(0, 7) == 0;
      step();
    end
    RST = 1'b0;
    InValid = 1'b0;
    Halt = 1'b0;
    ErrClr = 1'b0;
    repeat (40) step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
